// File: rtl/dense_input_collector_if.sv
// rtl/dense_input_collector_if.sv - sample-in / vector-out handshake bundle for the dense input collector
interface dense_input_collector_if #(
  parameter int WIDTH      = 16,
  parameter int INPUT_SIZE = 128
);
  logic                    in_valid;
  logic signed [WIDTH-1:0] in_data;
  logic                    in_ready;
  logic signed [WIDTH-1:0] out_data [INPUT_SIZE];
  logic                    out_valid;
  logic                    out_ack;
  logic [7:0]              frame_count;

  // master is the upstream/downstream environment, slave is the collector
  modport master (
    output in_valid, in_data, out_ack,
    input  in_ready, out_data, out_valid, frame_count
  );

  modport slave (
    input  in_valid, in_data, out_ack,
    output in_ready, out_data, out_valid, frame_count
  );
endinterface

// File: rtl/dense_input_collector.sv
// rtl/dense_input_collector.sv - ping-pong collector assembling streamed samples into dense-layer input vectors
module dense_input_collector #(
  parameter int WIDTH      = 16,
  parameter int INPUT_SIZE = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  dense_input_collector_if.slave bus
);
  localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_SIZE - 1);

  logic signed [WIDTH-1:0] mem_q [2][INPUT_SIZE];
  logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [1:0]              full_q, full_d;
  logic [7:0]              frame_cnt_q, frame_cnt_d;
  logic                    in_ready, out_valid, xfer, ack;

  assign in_ready        = ~full_q[wr_bank_q];
  assign out_valid       = full_q[rd_bank_q];
  assign xfer            = bus.in_valid & in_ready;
  assign ack             = out_valid & bus.out_ack;

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.frame_count = frame_cnt_q;
  assign bus.out_data    = mem_q[rd_bank_q];

  // A completing transfer needs wr_bank empty while an ack needs rd_bank full,
  // so when both fire in one cycle they always touch different full flags.
  always_comb begin
    wr_idx_d    = wr_idx_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    frame_cnt_d = frame_cnt_q;
    if (xfer) begin
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end
    if (ack) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      frame_cnt_d       = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      frame_cnt_q <= 8'd0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < INPUT_SIZE; k++) begin
          mem_q[b][k] <= '0;
        end
      end
    end else if (xfer) begin
      mem_q[wr_bank_q][wr_idx_q] <= bus.in_data;
    end
  end
endmodule

// File: tb/tb_dense_input_collector.sv
// tb/tb_dense_input_collector.sv - directed table, corner-case sequences and scoreboarded back-pressure run
module tb_dense_input_collector;
  localparam int N = 128;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dense_input_collector_if #(.WIDTH(16), .INPUT_SIZE(N)) bus ();

  dense_input_collector #(.WIDTH(16), .INPUT_SIZE(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ack;
    logic        exp_ready;
    logic        exp_valid;
    logic [7:0]  exp_count;
    logic [15:0] exp_d0;
  } row_t;

  row_t        rows [6];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_frame [N];
  logic [15:0] sb [$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic a);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.out_ack  = a;
  endtask

  task automatic check_frame(input string name);
    int bad = 0;
    for (int k = 0; k < N; k++) begin
      if (16'(bus.out_data[k]) !== exp_frame[k]) bad++;
    end
    chk(name, 16'(bad), 16'd0);
  endtask

  // reset is held with a live transfer and ack to show it has priority
  task automatic do_reset(input string name);
    drive(1'b1, 16'hFFFF, 1'b1);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    drive(1'b0, 16'h0000, 1'b0);
    chk({name, "_ready"}, 16'(bus.in_ready), 16'd1);
    chk({name, "_valid"}, 16'(bus.out_valid), 16'd0);
    chk({name, "_count"}, 16'(bus.frame_count), 16'd0);
    for (int k = 0; k < N; k++) exp_frame[k] = 16'h0000;
    check_frame({name, "_data"});
  endtask

  initial begin
    int rdy_bad;
    int full_cnt, idx, acked, cyc;
    logic v, a, exp_r, exp_v;

    rows[0] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 8'd0, 16'h0000};
    rows[1] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 8'd0, 16'h0000};
    rows[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'd1, 16'h8000};
    rows[3] = '{1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b1, 8'd1, 16'h8000};
    rows[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd2, 16'h7FFF};
    rows[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd2, 16'h7FFF};

    drive(1'b0, 16'h0000, 1'b0);
    do_reset("rst0");

    // frame 0: value = index, no ack
    rdy_bad = 0;
    for (int k = 0; k < N; k++) begin
      drive(1'b1, 16'(k), 1'b0);
      if (bus.in_ready !== 1'b1) rdy_bad++;
      if (k == N - 1) chk("f0_valid_early", 16'(bus.out_valid), 16'd0);
      tick();
      exp_frame[k] = 16'(k);
    end
    chk("f0_ready_held", 16'(rdy_bad), 16'd0);
    chk("f0_valid", 16'(bus.out_valid), 16'd1);
    check_frame("f0_data");

    // frame 1 fills the second bank while frame 0 stays on display
    rdy_bad = 0;
    for (int k = 0; k < N; k++) begin
      drive(1'b1, 16'h8000 + 16'(k), 1'b0);
      if (bus.in_ready !== 1'b1) rdy_bad++;
      tick();
    end
    chk("f1_ready_held", 16'(rdy_bad), 16'd0);
    chk("f1_ready_full", 16'(bus.in_ready), 16'd0);
    chk("f1_valid", 16'(bus.out_valid), 16'd1);
    check_frame("f1_still_f0");

    for (int r = 0; r < 6; r++) begin
      drive(rows[r].in_valid, rows[r].in_data, rows[r].out_ack);
      tick();
      chk($sformatf("row%0d_ready", r), 16'(bus.in_ready), 16'(rows[r].exp_ready));
      chk($sformatf("row%0d_valid", r), 16'(bus.out_valid), 16'(rows[r].exp_valid));
      chk($sformatf("row%0d_count", r), 16'(bus.frame_count), 16'(rows[r].exp_count));
      chk($sformatf("row%0d_d0", r), 16'(bus.out_data[0]), rows[r].exp_d0);
    end

    // frame A completes bank 0 (its sample 0 came from the table)
    exp_frame[0] = 16'h7FFF;
    for (int k = 1; k < N; k++) begin
      drive(1'b1, 16'h7FFF - 16'(k), 1'b0);
      tick();
      exp_frame[k] = 16'h7FFF - 16'(k);
    end
    chk("fa_valid", 16'(bus.out_valid), 16'd1);
    chk("fa_count", 16'(bus.frame_count), 16'd2);
    check_frame("fa_data");

    // frame B: its last sample coincides with the ack of frame A
    for (int k = 0; k < N; k++) begin
      drive(1'b1, 16'h4000 + 16'(3 * k), k == N - 1);
      if (k == N - 1) chk("fb_valid_before", 16'(bus.out_valid), 16'd1);
      tick();
      exp_frame[k] = 16'h4000 + 16'(3 * k);
    end
    drive(1'b0, 16'h0000, 1'b0);
    chk("fb_valid", 16'(bus.out_valid), 16'd1);
    chk("fb_count", 16'(bus.frame_count), 16'd3);
    chk("fb_ready", 16'(bus.in_ready), 16'd1);
    check_frame("fb_data");

    // reset in the middle of a frame
    for (int k = 0; k < 50; k++) begin
      drive(1'b1, 16'h1111, 1'b0);
      tick();
    end
    do_reset("rst1");
    for (int k = 0; k < N; k++) begin
      drive(1'b1, 16'h0400, 1'b0);
      if (k == N - 1) chk("pr_valid_early", 16'(bus.out_valid), 16'd0);
      tick();
      exp_frame[k] = 16'h0400;
    end
    drive(1'b0, 16'h0000, 1'b0);
    chk("pr_valid", 16'(bus.out_valid), 16'd1);
    chk("pr_count", 16'(bus.frame_count), 16'd0);
    check_frame("pr_data");

    // random back-pressure against a sample-queue scoreboard
    do_reset("rst2");
    full_cnt = 0;
    idx = 0;
    acked = 0;
    cyc = 0;
    while (acked < 300 && cyc < 90000) begin
      v = ($urandom % 10) != 0;
      a = ($urandom % 3) == 0;
      drive(v, 16'($urandom), a);
      exp_r = full_cnt < 2;
      exp_v = full_cnt > 0;
      chk("rnd_ready", 16'(bus.in_ready), 16'(exp_r));
      chk("rnd_valid", 16'(bus.out_valid), 16'(exp_v));
      if (a && exp_v) begin
        rdy_bad = 0;
        for (int k = 0; k < N; k++) begin
          if (k >= sb.size() || 16'(bus.out_data[k]) !== sb[k]) rdy_bad++;
        end
        chk($sformatf("rnd_frame%0d", acked), 16'(rdy_bad), 16'd0);
        for (int k = 0; k < N && sb.size() > 0; k++) void'(sb.pop_front());
        acked++;
        full_cnt--;
      end
      if (v && exp_r) begin
        sb.push_back(bus.in_data);
        idx++;
        if (idx == N) begin
          idx = 0;
          full_cnt++;
        end
      end
      tick();
      cyc++;
    end
    drive(1'b0, 16'h0000, 1'b0);
    chk("rnd_frames_done", 16'(acked), 16'd300);
    chk("rnd_count", 16'(bus.frame_count), 16'd44);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dense_input_collector.md
DENSE_INPUT_COLLECTOR -- requirements
Module: dense_input_collector

Interface
REQ-001 Parameter WIDTH, default 16, bits per fixed-point sample (Q6.10, NFRAC=10 carried through untouched).
REQ-002 Parameter INPUT_SIZE, default 128, samples per assembled vector (dense column input width).
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 Port in_valid  input  1  upstream (conv/flatten) sample present.
REQ-006 Port in_data  input  signed WIDTH  upstream sample.
REQ-007 Port in_ready  output  1  collector can accept a sample this cycle.
REQ-008 Port out_data  output  signed WIDTH x INPUT_SIZE unpacked array  assembled vector for the dense columns.
REQ-009 Port out_valid  output  1  out_data holds a complete vector.
REQ-010 Port out_ack  input  1  downstream done with the current vector (dense result captured).
REQ-011 Port frame_count  output  8  number of vectors acknowledged, modulo 256.

Function
REQ-012 Two storage banks (0,1) of INPUT_SIZE x WIDTH registers, each with a full flag; write pointer wr_idx (0..INPUT_SIZE-1), write bank wr_bank, read bank rd_bank.
REQ-013 Transfer occurs when in_valid && in_ready; only then is in_data written to bank[wr_bank][wr_idx].
REQ-014 in_ready = ~full[wr_bank] (combinational from registers, not from in_valid or out_ack).
REQ-015 Ordering: k-th sample accepted in a frame (k from 0) appears at out_data[k]; no reversal, no reordering.
REQ-016 On transfer with wr_idx < INPUT_SIZE-1: wr_idx increments, bank unchanged.
REQ-017 On transfer with wr_idx == INPUT_SIZE-1: wr_idx wraps to 0, full[wr_bank] sets, wr_bank toggles.
REQ-018 out_valid = full[rd_bank]; out_data = bank[rd_bank] contents; out_valid rises the cycle after the last sample of a frame is accepted (latency 1 from final transfer).
REQ-019 While out_valid is high and out_ack is low, out_data and out_valid are held stable.
REQ-020 On out_valid && out_ack: full[rd_bank] clears, rd_bank toggles, frame_count increments (wraps 255 -> 0).
REQ-021 out_ack while out_valid is low is ignored (no state change).
REQ-022 Simultaneous final-sample transfer into one bank and ack of the other bank in the same cycle: both take effect; no sample lost, no spurious out_valid drop if the newly filled bank becomes rd_bank.
REQ-023 Both banks full: in_ready low; incoming samples stall, none are overwritten or dropped.
REQ-024 Sustained throughput: one sample per cycle with out_ack asserted within INPUT_SIZE cycles of out_valid, with no in_ready deassertion.
REQ-025 Stored data is never altered by the collector (no saturation, truncation or sign change).

Reset
REQ-026 On reset: wr_idx=0, wr_bank=0, rd_bank=0, both full flags=0, frame_count=0, all storage=0; thus in_ready=1, out_valid=0, out_data all zeros the cycle after reset.
REQ-027 Reset mid-frame discards the partial frame and any full banks; the first sample after reset lands in out_data[0].
REQ-028 Reset has priority over any simultaneous transfer or out_ack.

Verification
REQ-029 Reset, then stream 128 samples value = index (0..127), one per cycle, out_ack low -> out_valid rises cycle after sample 127, out_data[k]=k, in_ready stays 1.
REQ-030 Continue streaming 128 more samples (value 16'h8000+index) with out_ack held low -> second bank fills, in_ready goes 0 after its last sample, further in_valid pulses stall; out_data still shows frame 0.
REQ-031 Assert out_ack one cycle -> out_data switches to frame 1 (out_data[0]=16'h8000), out_valid stays 1, in_ready returns 1, frame_count=1.
REQ-032 Final sample of frame N and out_ack of frame N-1 in same cycle -> next cycle out_valid=1 showing frame N, frame_count incremented, no data loss.
REQ-033 Assert reset after 50 samples of a frame, then send 128 samples of 16'h0400 -> out_valid only after the 128th post-reset sample, all elements 16'h0400, frame_count=0.
REQ-034 Random in_valid/out_ack back-pressure over 300 frames against a scoreboard -> every vector matches in order; frame_count = 300 mod 256 = 44.
